// File: rtl/hi_lo_unit_if.sv
// HI/LO unit bus: EX-stage request, status, and the external divider/multiplier links.
interface hi_lo_unit_if #(
  parameter int unsigned BitWidth = 32
);
  // EX-stage request
  logic                  start;
  logic [2:0]            op;
  logic [BitWidth-1:0]   operandA;
  logic [BitWidth-1:0]   operandB;
  logic                  flush;
  // status and architectural state
  logic                  busy;
  logic                  done;
  logic                  divByZero;
  logic [BitWidth-1:0]   hi;
  logic [BitWidth-1:0]   lo;
  // divider link
  logic                  divEnable;
  logic                  divUnsigned;
  logic [BitWidth-1:0]   divDividend;
  logic [BitWidth-1:0]   divDivisor;
  logic [BitWidth-1:0]   quotient;
  logic [BitWidth-1:0]   remainder;
  // multiplier link
  logic                  mulUnsigned;
  logic [BitWidth-1:0]   mulA;
  logic [BitWidth-1:0]   mulB;
  logic [2*BitWidth-1:0] product;

  // Pipeline plus external arithmetic units
  modport master (
    output start, op, operandA, operandB, flush, quotient, remainder, product,
    input  busy, done, divByZero, hi, lo,
    input  divEnable, divUnsigned, divDividend, divDivisor,
    input  mulUnsigned, mulA, mulB
  );

  // HI/LO sequencer
  modport slave (
    input  start, op, operandA, operandB, flush, quotient, remainder, product,
    output busy, done, divByZero, hi, lo,
    output divEnable, divUnsigned, divDividend, divDivisor,
    output mulUnsigned, mulA, mulB
  );
endinterface

// File: rtl/hi_lo_unit.sv
// HI/LO register holder and mult/div sequencer: latches operands onto the
// external multiplier or divider, holds them for a fixed window, then commits.
module hi_lo_unit #(
  parameter int unsigned BitWidth  = 32,
  parameter int unsigned DivCycles = 8,
  parameter int unsigned MulCycles = 3
) (
  input logic          clk,
  input logic          reset,
  hi_lo_unit_if.slave  bus
);

  localparam int unsigned MaxCycles = (DivCycles > MulCycles) ? DivCycles : MulCycles;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t              state;
  logic [CntW-1:0]     cnt;
  logic                busy_q;
  logic                done_q;
  logic                dbz_q;
  logic [BitWidth-1:0] hi_q;
  logic [BitWidth-1:0] lo_q;
  logic                div_en_q;
  logic                div_uns_q;
  logic [BitWidth-1:0] div_a_q;
  logic [BitWidth-1:0] div_b_q;
  logic                mul_uns_q;
  logic [BitWidth-1:0] mul_a_q;
  logic [BitWidth-1:0] mul_b_q;

  // Sequencer: accept, hold operands for the window, commit; flush wins over all
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      div_en_q  <= 1'b0;
      div_uns_q <= 1'b0;
      div_a_q   <= '0;
      div_b_q   <= '0;
      mul_uns_q <= 1'b0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        state    <= IDLE;
        cnt      <= '0;
        busy_q   <= 1'b0;
        div_en_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              case (bus.op)
                OpMult, OpMultu: begin
                  mul_a_q   <= bus.operandA;
                  mul_b_q   <= bus.operandB;
                  mul_uns_q <= (bus.op == OpMultu);
                  cnt       <= CntW'(MulCycles - 1);
                  busy_q    <= 1'b1;
                  state     <= MUL;
                end
                OpDiv, OpDivu: begin
                  div_a_q   <= bus.operandA;
                  div_b_q   <= bus.operandB;
                  div_uns_q <= (bus.op == OpDivu);
                  div_en_q  <= 1'b1;
                  // a fresh nonzero divisor clears the sticky flag at accept
                  if (bus.operandB != '0) dbz_q <= 1'b0;
                  cnt       <= CntW'(DivCycles - 1);
                  busy_q    <= 1'b1;
                  state     <= DIV;
                end
                OpMthi:  hi_q <= bus.operandA;
                OpMtlo:  lo_q <= bus.operandA;
                default: ;
              endcase
            end
          end
          MUL: begin
            if (cnt == '0) begin
              {hi_q, lo_q} <= bus.product;
              done_q       <= 1'b1;
              busy_q       <= 1'b0;
              state        <= IDLE;
            end else begin
              cnt <= cnt - CntW'(1);
            end
          end
          DIV: begin
            if (cnt == '0) begin
              if (div_b_q == '0) begin
                dbz_q <= 1'b1;
              end else begin
                lo_q <= bus.quotient;
                hi_q <= bus.remainder;
              end
              div_en_q <= 1'b0;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state    <= IDLE;
            end else begin
              cnt <= cnt - CntW'(1);
            end
          end
          default: begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            div_en_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.divByZero   = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.divEnable   = div_en_q;
  assign bus.divUnsigned = div_uns_q;
  assign bus.divDividend = div_a_q;
  assign bus.divDivisor  = div_b_q;
  assign bus.mulUnsigned = mul_uns_q;
  assign bus.mulA        = mul_a_q;
  assign bus.mulB        = mul_b_q;

endmodule

// File: tb/tb_hi_lo_unit.sv
// Directed bench for hi_lo_unit with behavioural divider and multiplier.
module tb_hi_lo_unit;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  hi_lo_unit_if #(.BitWidth(32)) bus ();

  hi_lo_unit #(.BitWidth(32), .DivCycles(8), .MulCycles(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural divider: truncating quotient, remainder follows dividend sign
  always_comb begin
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = bus.divDividend;
    sb = bus.divDivisor;
    if (bus.divDivisor == 32'd0) begin
      bus.quotient  = 32'hDEADBEEF;
      bus.remainder = 32'hBADC0DE5;
    end else if (bus.divUnsigned) begin
      bus.quotient  = bus.divDividend / bus.divDivisor;
      bus.remainder = bus.divDividend % bus.divDivisor;
    end else begin
      bus.quotient  = 32'(sa / sb);
      bus.remainder = 32'(sa % sb);
    end
  end

  // Behavioural multiplier
  always_comb begin
    logic signed [63:0] pa;
    logic signed [63:0] pb;
    pa = {{32{bus.mulA[31]}}, bus.mulA};
    pb = {{32{bus.mulB[31]}}, bus.mulB};
    if (bus.mulUnsigned) bus.product = {32'd0, bus.mulA} * {32'd0, bus.mulB};
    else                 bus.product = 64'(pa * pb);
  end

  // Present one request for a single edge; called and returns on a falling edge
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.start    = 1'b1;
    bus.op       = o;
    bus.operandA = a;
    bus.operandB = b;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.op       = 3'd0;
  endtask

  // Count falling edges with busy high (bounded)
  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
    checks++; if (bus.lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
    checks++; if (bus.divByZero !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", bus.divByZero); end
    checks++; if (bus.divEnable !== 1'b0) begin failures++; $display("FAIL reset_diven got=%b exp=0", bus.divEnable); end
    checks++; if (bus.mulA !== 32'd0 || bus.divDividend !== 32'd0) begin failures++; $display("FAIL reset_operands got=%h/%h exp=0/0", bus.mulA, bus.divDividend); end
  endtask

  task automatic test_div_signed();
    int n;
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    checks++; if (bus.divEnable !== 1'b1) begin failures++; $display("FAIL divs_enable got=%b exp=1", bus.divEnable); end
    checks++; if (bus.divUnsigned !== 1'b0) begin failures++; $display("FAIL divs_unsigned got=%b exp=0", bus.divUnsigned); end
    count_busy(n);
    checks++; if (n != 8) begin failures++; $display("FAIL divs_busy_cycles got=%0d exp=8", n); end
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL divs_lo got=%h exp=FFFFFFFD", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL divs_hi got=%h exp=FFFFFFFF", bus.hi); end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL divs_done got=%b exp=1", bus.done); end
    checks++; if (bus.divEnable !== 1'b0) begin failures++; $display("FAIL divs_enable_clr got=%b exp=0", bus.divEnable); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL divs_done_once got=%b exp=0", bus.done); end
  endtask

  task automatic test_divu_ignore();
    int n;
    issue(OP_DIVU, 32'hFFFFFFFF, 32'h10);
    checks++; if (bus.divUnsigned !== 1'b1) begin failures++; $display("FAIL divu_unsigned got=%b exp=1", bus.divUnsigned); end
    @(negedge clk);
    issue(OP_MTHI, 32'h1234, 32'd0);
    count_busy(n);
    checks++; if (n != 6) begin failures++; $display("FAIL divu_busy_rest got=%0d exp=6", n); end
    checks++; if (bus.lo !== 32'h0FFFFFFF) begin failures++; $display("FAIL divu_lo got=%h exp=0FFFFFFF", bus.lo); end
    checks++; if (bus.hi !== 32'h0000000F) begin failures++; $display("FAIL divu_hi got=%h exp=0000000F", bus.hi); end
    @(negedge clk);
  endtask

  task automatic test_mult();
    int n;
    issue(OP_MULT, 32'hFFFFFFFD, 32'd5);
    checks++; if (bus.mulUnsigned !== 1'b0) begin failures++; $display("FAIL mult_unsigned got=%b exp=0", bus.mulUnsigned); end
    count_busy(n);
    checks++; if (n != 3) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=3", n); end
    checks++; if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFF1) begin failures++; $display("FAIL mult_hilo got=%h_%h exp=FFFFFFFF_FFFFFFF1", bus.hi, bus.lo); end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL mult_done got=%b exp=1", bus.done); end
    @(negedge clk);
    issue(OP_MULTU, 32'hFFFFFFFD, 32'd5);
    checks++; if (bus.mulUnsigned !== 1'b1) begin failures++; $display("FAIL multu_unsigned got=%b exp=1", bus.mulUnsigned); end
    count_busy(n);
    checks++; if (n != 3) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=3", n); end
    checks++; if (bus.hi !== 32'h00000004 || bus.lo !== 32'hFFFFFFF1) begin failures++; $display("FAIL multu_hilo got=%h_%h exp=00000004_FFFFFFF1", bus.hi, bus.lo); end
    @(negedge clk);
  endtask

  task automatic test_mthi_mtlo();
    issue(OP_MTHI, 32'hAAAA5555, 32'd0);
    checks++; if (bus.hi !== 32'hAAAA5555) begin failures++; $display("FAIL mthi_hi got=%h exp=AAAA5555", bus.hi); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mthi_busy got=%b exp=0", bus.busy); end
    issue(OP_MTLO, 32'h0F0F0F0F, 32'd0);
    checks++; if (bus.lo !== 32'h0F0F0F0F || bus.hi !== 32'hAAAA5555) begin failures++; $display("FAIL mtlo_hilo got=%h_%h exp=AAAA5555_0F0F0F0F", bus.hi, bus.lo); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL mtlo_busy_done got=%b%b exp=00", bus.busy, bus.done); end
  endtask

  task automatic test_div_by_zero();
    int n;
    issue(OP_MTHI, 32'd1, 32'd0);
    issue(OP_MTLO, 32'd2, 32'd0);
    issue(OP_DIV, 32'd5, 32'd0);
    count_busy(n);
    checks++; if (n != 8) begin failures++; $display("FAIL dbz_busy_cycles got=%0d exp=8", n); end
    checks++; if (bus.hi !== 32'd1 || bus.lo !== 32'd2) begin failures++; $display("FAIL dbz_hilo got=%h_%h exp=00000001_00000002", bus.hi, bus.lo); end
    checks++; if (bus.divByZero !== 1'b1) begin failures++; $display("FAIL dbz_flag got=%b exp=1", bus.divByZero); end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL dbz_done got=%b exp=1", bus.done); end
    @(negedge clk);
    issue(OP_DIV, 32'd10, 32'd3);
    count_busy(n);
    checks++; if (bus.lo !== 32'd3 || bus.hi !== 32'd1) begin failures++; $display("FAIL div10_3_hilo got=%h_%h exp=00000001_00000003", bus.hi, bus.lo); end
    checks++; if (bus.divByZero !== 1'b0) begin failures++; $display("FAIL div10_3_dbz got=%b exp=0", bus.divByZero); end
    @(negedge clk);
  endtask

  task automatic test_flush();
    issue(OP_MTHI, 32'h11, 32'd0);
    issue(OP_MTLO, 32'h22, 32'd0);
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.divEnable !== 1'b0) begin failures++; $display("FAIL flush_busy_en got=%b%b exp=00", bus.busy, bus.divEnable); end
    checks++; if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin failures++; $display("FAIL flush_hilo got=%h_%h exp=00000011_00000022", bus.hi, bus.lo); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL flush_done got=%b exp=0", bus.done); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL flush_done_late got=%b exp=0", bus.done); end
    // flush landing exactly on the commit edge drops the commit
    issue(OP_MULT, 32'd7, 32'd9);
    repeat (2) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++; if (bus.hi !== 32'h11 || bus.lo !== 32'h22 || bus.done !== 1'b0) begin failures++; $display("FAIL flush_commit_edge got=%h_%h done=%b exp=00000011_00000022 done=0", bus.hi, bus.lo, bus.done); end
    // start together with flush is discarded
    bus.flush = 1'b1;
    issue(OP_MULT, 32'd7, 32'd9);
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL flush_start_busy got=%b exp=0", bus.busy); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL flush_start_late got=%b%b exp=00", bus.busy, bus.done); end
  endtask

  task automatic test_reset_mid();
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.divEnable !== 1'b0) begin failures++; $display("FAIL rstmid_busy_en got=%b%b exp=00", bus.busy, bus.divEnable); end
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin failures++; $display("FAIL rstmid_hilo got=%h_%h exp=0_0", bus.hi, bus.lo); end
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin failures++; $display("FAIL rstmid_no_commit got=%b %h_%h exp=0 0_0", bus.done, bus.hi, bus.lo); end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.op       = 3'd0;
    bus.operandA = 32'd0;
    bus.operandB = 32'd0;
    bus.flush    = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_div_signed();
    test_divu_ignore();
    test_mult();
    test_mthi_mtlo();
    test_div_by_zero();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hi_lo_unit.md
Name: hi_lo_unit

Overview:
- Sequencer and state holder for the MIPS HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and latches operands.
- Holds those operands stable on the external divider or multiplier for a fixed multicycle window, then commits the result to HI/LO.
- Asserts busy so the pipeline stalls later HI/LO consumers (MFHI/MFLO, new mult/div) until the commit.

Parameters:
BitWidth, 32, operand/HI/LO width
DivCycles, 8, cycles operands are held on the divider before commit (>=1)
MulCycles, 3, cycles operands are held on the multiplier before commit (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
start  input  1  request valid this cycle
op  input  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP
operandA  input  BitWidth  rs value (dividend / multiplicand / MTHI-MTLO data)
operandB  input  BitWidth  rt value (divisor / multiplier)
flush  input  1  cancel any in-flight operation (exception/branch squash)
busy  output  1  operation in flight; upstream must stall
done  output  1  one-cycle pulse, cycle after a mult/div commit
divByZero  output  1  sticky flag: last DIV/DIVU had divisor 0
hi  output  BitWidth  HI register
lo  output  BitWidth  LO register
divEnable  output  1  to divider enable
divUnsigned  output  1  to divider isUnsigned
divDividend  output  BitWidth  to divider dividend
divDivisor  output  BitWidth  to divider divisor
quotient  input  BitWidth  from divider
remainder  input  BitWidth  from divider
mulUnsigned  output  1  to multiplier
mulA  output  BitWidth  to multiplier
mulB  output  BitWidth  to multiplier
product  input  2*BitWidth  from multiplier, {high, low}

Behaviour:
- Reset: all outputs and internal registers are 0; state IDLE.
- States are IDLE, MUL and DIV. A down-counter tracks cycles remaining.
- IDLE with start=1 and op=MULT/MULTU:
  - Latch operands into mulA/mulB and mulUnsigned (=op==MULTU).
  - Load counter with MulCycles-1 and go to MUL.
- IDLE with start=1 and op=DIV/DIVU:
  - Latch operands into divDividend/divDivisor and divUnsigned.
  - Set divEnable=1, load counter with DivCycles-1, go to DIV.
- IDLE with start=1 and op=MTHI/MTLO: write operandA to hi/lo at that edge. busy stays 0 and done is not pulsed.
- busy = (state != IDLE), which is a registered state decode. busy is high for exactly N cycles after the accept edge (N = MulCycles or DivCycles).
- MUL/DIV with counter>0: decrement each cycle. Operand outputs stay constant.
- MUL/DIV with counter==0, at that edge:
  - MUL: {hi,lo} <= product.
  - DIV: lo <= quotient and hi <= remainder, unless divDivisor==0, in which case hi/lo are unchanged and divByZero is set.
  - divEnable clears, done=1 for the next cycle, return to IDLE.
- divByZero is cleared by any accepted DIV/DIVU with a nonzero divisor.
- start while busy is ignored. No queueing: upstream holds the instruction via the busy stall.
- flush has priority over everything:
  - State goes to IDLE, divEnable=0, no commit, done=0.
  - A simultaneous start is discarded.
  - hi/lo keep their prior values; a commit scheduled on the same edge is dropped.
- Reset asserted mid-operation clears immediately (async); no commit occurs.
- hi/lo are registered: MFHI/MFLO see a new value the cycle after the commit edge.
- Operand outputs are driven only from registers, so the divider/multiplier inputs are glitch-free for the whole multicycle window.
- Signed semantics are those of the divider: quotient truncates toward zero; remainder takes the dividend's sign.

Test Plan:
- DIV operandA=0xFFFFFFF9 (-7), operandB=2 -> busy high 8 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF, done pulses once.
- DIVU 0xFFFFFFFF / 0x10 -> lo=0x0FFFFFFF, hi=0x0000000F; a start issued during busy (MTHI 0x1234) is ignored, so hi remains 0x0000000F.
- MULT 0xFFFFFFFD (-3) * 5 with product model -> after 3 busy cycles hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULTU same operands -> hi=0x00000004, lo=0xFFFFFFF1.
- MTHI 0xAAAA5555 then next cycle MTLO 0x0F0F0F0F -> hi/lo updated one edge each, busy never high.
- DIV x/0 with hi=1, lo=2 beforehand -> after 8 cycles hi=1, lo=2, divByZero=1, done pulses. A following DIV 10/3 -> lo=3, hi=1, divByZero=0.
- DIV started, flush on cycle 4 (and separately reset on cycle 4) -> busy low next cycle (immediately for reset), divEnable=0, hi/lo unchanged (zero after reset), no done pulse.
